// File: rtl/alu2_sweeper_if.sv
// Signal bundle between the alu2_sweeper sequencer and the 2-bit ALU under test.
// The master side drives the ALU operands and results; the slave side drives start and F.
interface alu2_sweeper_if;
  logic       start;
  logic [1:0] A;
  logic [1:0] B;
  logic [1:0] I;
  logic [1:0] F;
  logic       busy;
  logic       done;
  logic       pass;
  logic [6:0] err_count;
  logic       fail_valid;
  logic [5:0] first_fail;

  modport master (
    input  start, F,
    output A, B, I, busy, done, pass, err_count, fail_valid, first_fail
  );

  modport slave (
    output start, F,
    input  A, B, I, busy, done, pass, err_count, fail_valid, first_fail
  );
endinterface

// File: rtl/alu2_sweeper.sv
// Sweeps all 64 {I,A,B} vectors into a 2-bit ALU and checks F against a golden model.
// Optional macro ALU2_SWEEP_STOP_ON_FAIL_EN: end the sweep at the first mismatch.
module alu2_sweeper #(
  parameter int unsigned SETTLE = 1
) (
  input  logic           clk,
  input  logic           rst,
  alu2_sweeper_if.master bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_v;
  logic [3:0] r_cnt;
  logic [6:0] r_err;
  logic       r_fail_valid;
  logic [5:0] r_first_fail;
  logic       r_pass;

  logic [1:0] w_gold;
  logic       w_sample;
  logic       w_mismatch;
  logic       w_finish;
  logic       w_start_sweep;

  always_comb begin
    w_gold = '0;
    case (r_v[5:4])
      2'b00:   w_gold = r_v[3:2] & r_v[1:0];
      2'b01:   w_gold = r_v[3:2] | r_v[1:0];
      2'b10:   w_gold = ~(r_v[3:2] ^ r_v[1:0]);
      default: w_gold = ~r_v[3:2];
    endcase
  end

  assign w_sample      = (r_state == S_RUN) && (r_cnt == SETTLE_CNT);
  assign w_mismatch    = w_sample && (bus.F != w_gold);
  assign w_start_sweep = (r_state != S_RUN) && bus.start;

`ifdef ALU2_SWEEP_STOP_ON_FAIL_EN
  assign w_finish = w_sample && ((r_v == 6'd63) || w_mismatch);
`else
  assign w_finish = w_sample && (r_v == 6'd63);
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_RUN;
      S_RUN:   if (w_finish)  w_next = S_DONE;
      S_DONE:  if (bus.start) w_next = S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  // v is not advanced on the finishing compare so A/B/I hold the last checked vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_v          <= '0;
      r_cnt        <= '0;
      r_err        <= '0;
      r_fail_valid <= 1'b0;
      r_first_fail <= '0;
      r_pass       <= 1'b0;
    end else if (w_start_sweep) begin
      r_v          <= '0;
      r_cnt        <= '0;
      r_err        <= '0;
      r_fail_valid <= 1'b0;
      r_first_fail <= '0;
      r_pass       <= 1'b0;
    end else if (w_sample) begin
      r_cnt <= '0;
      if (w_mismatch) begin
        r_err <= r_err + 7'd1;
        if (!r_fail_valid) begin
          r_first_fail <= r_v;
          r_fail_valid <= 1'b1;
        end
      end
      if (w_finish) r_pass <= (r_err == '0) && !w_mismatch;
      else          r_v    <= r_v + 6'd1;
    end else if (r_state == S_RUN) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  assign bus.I          = r_v[5:4];
  assign bus.A          = r_v[3:2];
  assign bus.B          = r_v[1:0];
  assign bus.busy       = (r_state == S_RUN);
  assign bus.done       = (r_state == S_DONE);
  assign bus.pass       = r_pass;
  assign bus.err_count  = r_err;
  assign bus.fail_valid = r_fail_valid;
  assign bus.first_fail = r_first_fail;

endmodule

// File: tb/tb_alu2_sweeper.sv
// Scoreboard bench for alu2_sweeper: a behavioural ALU (with injectable faults) closes the loop,
// expected sweep results are queued per start and checked when done rises.
module tb_alu2_sweeper;

  logic clk = 1'b0;
  logic rst;
  int   fault;   // 0 = correct ALU, 1 = F stuck at 00, 2 = XNOR replaced by XOR

  always #5 clk = ~clk;

  alu2_sweeper_if bus ();
  alu2_sweeper_if bus0 ();

  alu2_sweeper #(.SETTLE(1)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
  alu2_sweeper #(.SETTLE(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

  function automatic logic [1:0] alu_ref(logic [1:0] i, logic [1:0] a, logic [1:0] b, int f);
    logic [1:0] r;
    if (f == 1) return 2'b00;
    case (i)
      2'b00:   r = a & b;
      2'b01:   r = a | b;
      2'b10:   r = (f == 2) ? (a ^ b) : ~(a ^ b);
      default: r = ~a;
    endcase
    return r;
  endfunction

  always_comb bus.F  = alu_ref(bus.I, bus.A, bus.B, fault);
  always_comb bus0.F = alu_ref(bus0.I, bus0.A, bus0.B, 0);

  int n_checks = 0;
  int n_passed = 0;

  task automatic chk(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    string tag;
    int    pass;
    int    err;
    int    fv;
    int    ff;
    int    cycles;
    int    lastv;
  } exp_t;

  exp_t sbq[$];

  task automatic push(string tag, int pass, int err, int fv, int ff, int cycles, int lastv);
    exp_t e;
    e.tag = tag; e.pass = pass; e.err = err; e.fv = fv; e.ff = ff;
    e.cycles = cycles; e.lastv = lastv;
    sbq.push_back(e);
  endtask

  // Monitor: counts busy cycles per sweep and scores each done rising edge.
  int   busy_cyc = 0;
  logic prev_busy = 1'b0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (bus.busy && !prev_busy) busy_cyc = 1;
    else if (bus.busy)          busy_cyc++;
    if (bus.done && !prev_done) begin
      if (sbq.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = sbq.pop_front();
        chk({e.tag, "_pass"},       int'(bus.pass),       e.pass);
        chk({e.tag, "_err_count"},  int'(bus.err_count),  e.err);
        chk({e.tag, "_fail_valid"}, int'(bus.fail_valid), e.fv);
        chk({e.tag, "_first_fail"}, int'(bus.first_fail), e.ff);
        chk({e.tag, "_busy_cycles"}, busy_cyc,            e.cycles);
        chk({e.tag, "_held_vector"}, int'({bus.I, bus.A, bus.B}), e.lastv);
        chk({e.tag, "_busy_low"},   int'(bus.busy),       0);
      end
    end
    prev_busy = bus.busy;
    prev_done = bus.done;
  end

  task automatic pulse_start();
    @(negedge clk) bus.start = 1'b1;
    @(negedge clk) bus.start = 1'b0;
  endtask

  task automatic wait_done(string name, int budget);
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (bus.done) break;
    end
    chk({name, "_done_seen"}, int'(bus.done), 1);
  endtask

  task automatic check_reset_outputs(string name);
    chk({name, "_A"},          int'(bus.A),          0);
    chk({name, "_B"},          int'(bus.B),          0);
    chk({name, "_I"},          int'(bus.I),          0);
    chk({name, "_busy"},       int'(bus.busy),       0);
    chk({name, "_done"},       int'(bus.done),       0);
    chk({name, "_pass"},       int'(bus.pass),       0);
    chk({name, "_err_count"},  int'(bus.err_count),  0);
    chk({name, "_fail_valid"}, int'(bus.fail_valid), 0);
    chk({name, "_first_fail"}, int'(bus.first_fail), 0);
  endtask

  initial begin
    int cyc0;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus0.start = 1'b0;
    fault      = 0;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk) rst = 1'b0;

    // Correct ALU
    fault = 0;
    push("good", 1, 0, 0, 0, 128, 63);
    pulse_start();
    wait_done("good", 300);

    // F stuck at 00
    fault = 1;
`ifdef ALU2_SWEEP_STOP_ON_FAIL_EN
    push("stuck0", 0, 1, 1, 5, 12, 5);
`else
    push("stuck0", 0, 46, 1, 5, 128, 63);
`endif
    pulse_start();
    wait_done("stuck0", 300);

    // XNOR implemented as XOR
    fault = 2;
`ifdef ALU2_SWEEP_STOP_ON_FAIL_EN
    push("xor", 0, 1, 1, 32, 66, 32);
`else
    push("xor", 0, 16, 1, 32, 128, 63);
`endif
    pulse_start();
    wait_done("xor", 300);

    // Reset mid-sweep at vector 20, then a clean sweep
    fault = 1;
    pulse_start();
    for (int k = 0; k < 200; k++) begin
      if (bus.busy && ({bus.I, bus.A, bus.B} == 6'd20)) break;
      @(negedge clk);
    end
    chk("abort_reached_v20", int'({bus.I, bus.A, bus.B}), 20);
    rst = 1'b1;
    @(posedge clk);
    #1 check_reset_outputs("abort");
    @(negedge clk) rst = 1'b0;
    fault = 0;
    push("after_abort", 1, 0, 0, 0, 128, 63);
    pulse_start();
    wait_done("after_abort", 300);

    // start held high: one failing sweep, then an immediate restart that clears results
    fault = 1;
`ifdef ALU2_SWEEP_STOP_ON_FAIL_EN
    push("held1", 0, 1, 1, 5, 12, 5);
`else
    push("held1", 0, 46, 1, 5, 128, 63);
`endif
    push("held2", 1, 0, 0, 0, 128, 63);
    @(negedge clk) bus.start = 1'b1;
    wait_done("held1", 300);
    fault = 0;
    @(negedge clk);
    chk("restart_busy",       int'(bus.busy),       1);
    chk("restart_done",       int'(bus.done),       0);
    chk("restart_err_count",  int'(bus.err_count),  0);
    chk("restart_fail_valid", int'(bus.fail_valid), 0);
    chk("restart_first_fail", int'(bus.first_fail), 0);
    chk("restart_vector",     int'({bus.I, bus.A, bus.B}), 0);
    bus.start = 1'b0;
    wait_done("held2", 300);

    // SETTLE=0 instance
    cyc0 = 0;
    @(negedge clk) bus0.start = 1'b1;
    @(negedge clk) bus0.start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (bus0.done) break;
      if (bus0.busy) cyc0++;
      @(negedge clk);
    end
    chk("settle0_done",        int'(bus0.done),      1);
    chk("settle0_busy_cycles", cyc0,                 64);
    chk("settle0_pass",        int'(bus0.pass),      1);
    chk("settle0_err_count",   int'(bus0.err_count), 0);

    @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
